// File: rtl/mux4_reg.sv
// Registered 4:1 mux with a one-cycle strobe when the accepted select changes.
// Optional parity output m_par is enabled by defining MUX4_REG_PARITY_EN.
module mux4_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] m_out,
`ifdef MUX4_REG_PARITY_EN
  output logic             sel_chg,
  output logic             m_par
`else
  output logic             sel_chg
`endif
);

  logic [WIDTH-1:0] r_out;
  logic [1:0]       r_sel_q;
  logic             r_chg;
  logic [WIDTH-1:0] w_data;
  logic             w_sel_known;

  // The default arm only matters in simulation, when select carries X/Z bits.
  always_comb begin
    w_data      = '0;
    w_sel_known = 1'b1;
    case (select)
      2'b00:   w_data = in_0;
      2'b01:   w_data = in_1;
      2'b10:   w_data = in_2;
      2'b11:   w_data = in_3;
      default: begin
        w_data      = '0;
        w_sel_known = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_sel_q <= 2'b00;
      r_chg   <= 1'b0;
    end else if (en) begin
      r_out <= w_data;
      if (w_sel_known) begin
        r_sel_q <= select;
        r_chg   <= (select != r_sel_q);
      end else begin
        r_chg <= 1'b0;
      end
    end else begin
      r_chg <= 1'b0;
    end
  end

  assign m_out   = r_out;
  assign sel_chg = r_chg;

`ifdef MUX4_REG_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (en) begin
      r_par <= ^w_data;
    end
  end

  assign m_par = r_par;
`endif

endmodule

// File: tb/tb_mux4_reg.sv
// Directed-vector bench for mux4_reg (WIDTH=8); checks m_par when MUX4_REG_PARITY_EN is defined.
module tb_mux4_reg;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] in_0, in_1, in_2, in_3;
  logic [1:0]       select;
  logic [WIDTH-1:0] m_out;
  logic             sel_chg;
`ifdef MUX4_REG_PARITY_EN
  logic             m_par;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mux4_reg #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .in_0    (in_0),
    .in_1    (in_1),
    .in_2    (in_2),
    .in_3    (in_3),
    .select  (select),
    .m_out   (m_out),
`ifdef MUX4_REG_PARITY_EN
    .sel_chg (sel_chg),
    .m_par   (m_par)
`else
    .sel_chg (sel_chg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       en;
    logic [1:0] sel;
    logic [7:0] i0, i1, i2, i3;
    logic [7:0] exp_out;
    logic       exp_chg;
    logic       exp_par;
  } vec_t;

  vec_t vecs[$];

  task automatic check_out(input string name, input logic [7:0] exp_out, input logic exp_chg,
                           input logic exp_par);
    n_checks++;
    if (m_out !== exp_out) begin
      n_fail++;
      $display("FAIL %s m_out: got %h expected %h", name, m_out, exp_out);
    end
    n_checks++;
    if (sel_chg !== exp_chg) begin
      n_fail++;
      $display("FAIL %s sel_chg: got %b expected %b", name, sel_chg, exp_chg);
    end
`ifdef MUX4_REG_PARITY_EN
    n_checks++;
    if (m_par !== exp_par) begin
      n_fail++;
      $display("FAIL %s m_par: got %b expected %b", name, m_par, exp_par);
    end
`endif
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst_n  = v.rst_n;
    en     = v.en;
    select = v.sel;
    in_0   = v.i0;
    in_1   = v.i1;
    in_2   = v.i2;
    in_3   = v.i3;
    @(posedge clk);
    #1;
    check_out(v.name, v.exp_out, v.exp_chg, v.exp_par);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; select = 2'b00;
    in_0 = '0; in_1 = '0; in_2 = '0; in_3 = '0;

    //            name         rst en sel  i0     i1     i2     i3     out    chg  par
    vecs.push_back('{"rst_a",   0, 1, 3, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 0, 0});
    vecs.push_back('{"rst_b",   0, 1, 3, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 0, 0});
    vecs.push_back('{"rel",     1, 1, 3, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 1, 1});
    vecs.push_back('{"rst_c",   0, 1, 3, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 0, 0});
    vecs.push_back('{"bas0",    1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0});
    vecs.push_back('{"bas1",    1, 1, 1, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 1, 1});
    vecs.push_back('{"bas1h",   1, 1, 1, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 0, 1});
    vecs.push_back('{"swp0",    1, 1, 0, 8'h11, 8'h22, 8'h44, 8'h88, 8'h11, 1, 0});
    vecs.push_back('{"swp1",    1, 1, 1, 8'h11, 8'h22, 8'h44, 8'h88, 8'h22, 1, 0});
    vecs.push_back('{"swp2",    1, 1, 2, 8'h11, 8'h22, 8'h44, 8'h88, 8'h44, 1, 0});
    vecs.push_back('{"swp3",    1, 1, 3, 8'h11, 8'h22, 8'h44, 8'h88, 8'h88, 1, 0});
    vecs.push_back('{"hld_s",   1, 1, 1, 8'h11, 8'h22, 8'h44, 8'h88, 8'h22, 1, 0});
    vecs.push_back('{"hld_a",   1, 0, 3, 8'h11, 8'hFF, 8'h44, 8'h88, 8'h22, 0, 0});
    vecs.push_back('{"hld_b",   1, 0, 3, 8'h11, 8'hFF, 8'h44, 8'h88, 8'h22, 0, 0});
    vecs.push_back('{"hld_re",  1, 1, 3, 8'h11, 8'hFF, 8'h44, 8'h88, 8'h88, 1, 0});
    vecs.push_back('{"mid_s",   1, 1, 2, 8'h11, 8'h22, 8'h44, 8'h88, 8'h44, 1, 0});
    vecs.push_back('{"mid_r",   0, 1, 2, 8'h11, 8'h22, 8'h44, 8'h88, 8'h00, 0, 0});
    vecs.push_back('{"mid_rl",  1, 1, 2, 8'h11, 8'h22, 8'h44, 8'h88, 8'h44, 1, 0});
    vecs.push_back('{"par1",    1, 1, 0, 8'h07, 8'h03, 8'h44, 8'h88, 8'h07, 1, 1});
    vecs.push_back('{"par0",    1, 1, 1, 8'h07, 8'h03, 8'h44, 8'h88, 8'h03, 1, 0});
    vecs.push_back('{"unsel",   1, 1, 1, 8'hFF, 8'h03, 8'hFE, 8'h7F, 8'h03, 0, 0});
    vecs.push_back('{"rst_en0", 0, 0, 1, 8'hFF, 8'h03, 8'hFE, 8'h7F, 8'h00, 0, 0});
    vecs.push_back('{"frst00",  1, 1, 0, 8'hFE, 8'h03, 8'hFE, 8'h7F, 8'hFE, 0, 1});
    vecs.push_back('{"en0par",  1, 0, 3, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFE, 0, 1});

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Input changes between edges must not reach m_out before the next edge.
    @(negedge clk);
    en = 1'b1; select = 2'b11; in_3 = 8'h5A;
    @(posedge clk); #1;
    check_out("seq_a", 8'h5A, 1'b1, 1'b0);
    in_3 = 8'hA5; select = 2'b00; in_0 = 8'h3C;
    #2;
    check_out("seq_mid", 8'h5A, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_out("seq_b", 8'h3C, 1'b1, 1'b0);

    // A single-cycle change pulse ends even if en is then held high on the same select.
    @(negedge clk);
    select = 2'b10; in_2 = 8'h01;
    @(posedge clk); #1;
    check_out("pls_on", 8'h01, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_out("pls_off", 8'h01, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/mux4_reg.md
Name: mux4_reg

Overview:
- Registered 4:1 multiplexer. Selects one of four equal-width data inputs by a 2-bit select and presents it on a clocked output.
- Used as a generic datapath steering element where a glitch-free, single-cycle-latency, registered selection is required.
- Provides a one-cycle strobe whenever the applied select differs from the previously accepted one.

Parameters:
- WIDTH, 1, bit width of each data input and of m_out (legal range ≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- en  input  1  capture enable; 1 = accept new selection this cycle, 0 = hold.
- in_0  input  WIDTH  data input selected when select = 2'b00.
- in_1  input  WIDTH  data input selected when select = 2'b01.
- in_2  input  WIDTH  data input selected when select = 2'b10.
- in_3  input  WIDTH  data input selected when select = 2'b11.
- select  input  2  input selector.
- m_out  output  WIDTH  registered selected data.
- sel_chg  output  1  one-cycle pulse: accepted select differs from previous accepted select.

Behaviour:
- Reset: rising clk with rst_n=0 forces m_out=0, internal sel_q=2'b00, sel_chg=0. Reset has priority over en. No asynchronous path.
- Normal operation, on rising clk with rst_n=1 and en=1:
  - m_out <= in_[select].
  - sel_q <= select.
  - sel_chg <= (select != sel_q).
- On rising clk with rst_n=1 and en=0:
  - m_out and sel_q hold.
  - sel_chg <= 0.
- Latency:
  - m_out reflects the inputs sampled at the previous rising edge, exactly 1 cycle.
  - Input changes between edges have no effect on m_out. No combinational path from any input to m_out or sel_chg.
- sel_chg:
  - Asserted for exactly one cycle per accepted select change.
  - Back-to-back changes on consecutive enabled cycles give consecutive pulses.
  - The first accepted select after reset compares against 2'b00.
- Unknown select (X/Z bits, simulation only): m_out <= 0 and sel_chg <= 0. sel_q holds.
- Data inputs with X values propagate as-is to m_out when selected. Unselected inputs never affect m_out.
- Reset asserted mid-operation: the next edge clears all outputs regardless of en/select. Operation resumes on the first edge with rst_n=1.
- All four data inputs are treated identically. No priority among inputs.

Optional Feature:
- Macro: MUX4_REG_PARITY_EN.
- When defined:
  - Adds output port m_par (1 bit, output, after sel_chg).
  - m_par is registered in the same cycle as m_out and equals the XOR reduction of the value loaded into m_out.
  - Reset value 0. Holds when en=0. 0 when select is unknown.
- When undefined: m_par port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset: rst_n=0 for 2 edges with in_0..in_3=1, select=2'b11, en=1 → m_out=0, sel_chg=0. Release rst_n → next edge m_out=1, sel_chg=1.
- Basic select (WIDTH=1): en=1, in_0=0, in_1=0, select=2'b00 → after 1 edge m_out=0, sel_chg=0. Then in_1=1, in_2=1, select=2'b01 → after next edge m_out=1, sel_chg=1 for one cycle, then 0 while select holds.
- Sweep (WIDTH=8): in_0=8'h11, in_1=8'h22, in_2=8'h44, in_3=8'h88, select stepped 00→01→10→11 on consecutive edges → m_out=11,22,44,88, each one cycle after its select is applied, with sel_chg=1 on each step.
- Hold: m_out=8'h22, then en=0, select=2'b11, in_1=8'hFF → m_out stays 22 and sel_chg=0. Re-assert en → next edge m_out=88, sel_chg=1.
- Mid-operation reset: while m_out=8'h44, rst_n=0 for one edge → m_out=00. rst_n=1 with select=2'b10 → m_out=44, sel_chg=1.
- Parity (macro defined, WIDTH=8): select input holding 8'h07 → m_par=1. Select 8'h03 → m_par=0.
